decode_execute_reg: RTL and testbench

Pipeline register between the Decode and Execute stages of the pipelined RV32I core. It captures the Decode-stage control word from the control unit and the Decode-stage datapath operands at each rising clock edge and presents them to Execute. It supports a hazard-unit stall (hold) and flush (bubble insertion), and tracks a valid bit. A saturating bubble counter is exposed for performance monitoring.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/flop_enr.sv | 22 ++
 rtl/decode_execute_reg.sv | 112 +++++++++++
 tb/tb_decode_execute_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the pipeline stage registers of the RV32I core.
// The execute-stage control word lives here so every stage register uses one layout.
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_e_t;

    // All-zero control word: no register write, no store, no jump, no branch.
    localparam ctrl_e_t CTRL_NOP = '0;

endpackage

// File: rtl/flop_enr.sv
// Generic register with synchronous reset, enable and synchronous clear.
// Priority is reset > clear > enable, so a clear wins over a hold.
module flop_enr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-Execute pipeline register with stall, flush (bubble insertion),
// a valid bit and a saturating count of inserted bubbles.
module decode_execute_reg #(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int CNTW = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_StallE,
    input  logic            i_FlushE,
    input  logic            i_ValidD,
    input  logic            i_RegWriteD,
    input  logic [1:0]      i_ResultSrcD,
    input  logic            i_MemWriteD,
    input  logic            i_JumpD,
    input  logic            i_BranchD,
    input  logic [2:0]      i_ALUControlD,
    input  logic            i_ALUSrcD,
    input  logic [XLEN-1:0] i_RD1D,
    input  logic [XLEN-1:0] i_RD2D,
    input  logic [XLEN-1:0] i_PCD,
    input  logic [XLEN-1:0] i_PCPlus4D,
    input  logic [XLEN-1:0] i_ImmExtD,
    input  logic [4:0]      i_Rs1D,
    input  logic [4:0]      i_Rs2D,
    input  logic [4:0]      i_RdD,
    output logic            o_ValidE,
    output logic            o_RegWriteE,
    output logic [1:0]      o_ResultSrcE,
    output logic            o_MemWriteE,
    output logic            o_JumpE,
    output logic            o_BranchE,
    output logic [2:0]      o_ALUControlE,
    output logic            o_ALUSrcE,
    output logic [XLEN-1:0] o_RD1E,
    output logic [XLEN-1:0] o_RD2E,
    output logic [XLEN-1:0] o_PCE,
    output logic [XLEN-1:0] o_PCPlus4E,
    output logic [XLEN-1:0] o_ImmExtE,
    output logic [4:0]      o_Rs1E,
    output logic [4:0]      o_Rs2E,
    output logic [4:0]      o_RdE,
    output logic [CNTW-1:0] o_BubbleCount
);

    localparam int CW = $bits(pipeline_pkg::ctrl_e_t) + 1;
    localparam int DW = 5 * XLEN + 15;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    pipeline_pkg::ctrl_e_t ctrl_d;
    pipeline_pkg::ctrl_e_t ctrl_e;
    logic [CW-1:0]         ctrl_q;
    logic [DW-1:0]         data_d;
    logic [DW-1:0]         data_q;
    logic [CNTW-1:0]       bubble_count;

    assign ctrl_d = '{
        reg_write:   i_RegWriteD,
        result_src:  i_ResultSrcD,
        mem_write:   i_MemWriteD,
        jump:        i_JumpD,
        branch:      i_BranchD,
        alu_control: i_ALUControlD,
        alu_src:     i_ALUSrcD
    };

    assign data_d = {i_RD1D, i_RD2D, i_PCD, i_PCPlus4D, i_ImmExtD, i_Rs1D, i_Rs2D, i_RdD};

    // Clearing to zero turns the control word into CTRL_NOP and drops valid.
    flop_enr #(.WIDTH(CW)) u_ctrl (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (~i_StallE),
        .clr   (i_FlushE),
        .d     ({i_ValidD, ctrl_d}),
        .q     (ctrl_q)
    );

    flop_enr #(.WIDTH(DW)) u_data (
        .clk   (i_clk),
        .reset (i_reset),
        .en    (~i_StallE),
        .clr   (i_FlushE),
        .d     (data_d),
        .q     (data_q)
    );

    assign o_ValidE = ctrl_q[CW-1];
    assign ctrl_e   = ctrl_q[CW-2:0];

    assign o_RegWriteE   = ctrl_e.reg_write;
    assign o_ResultSrcE  = ctrl_e.result_src;
    assign o_MemWriteE   = ctrl_e.mem_write;
    assign o_JumpE       = ctrl_e.jump;
    assign o_BranchE     = ctrl_e.branch;
    assign o_ALUControlE = ctrl_e.alu_control;
    assign o_ALUSrcE     = ctrl_e.alu_src;

    assign {o_RD1E, o_RD2E, o_PCE, o_PCPlus4E, o_ImmExtE, o_Rs1E, o_Rs2E, o_RdE} = data_q;

    // Every flush edge is one inserted bubble, even when a stall is also requested.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bubble_count <= '0;
        end else if (i_FlushE && (bubble_count != CNT_MAX)) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

    assign o_BubbleCount = bubble_count;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: directed scenarios followed by
// random reset/flush/stall/load traffic, all checked against a behavioural model.
module tb_decode_execute_reg;

    localparam int XLEN    = 32;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } stage_t;

    logic   clk;
    logic   reset;
    logic   stall;
    logic   flush;
    stage_t d;
    stage_t exp_e;
    int     exp_count;
    int     vectors;
    int     miscompares;

    logic            o_valid, o_reg_write, o_mem_write, o_jump, o_branch, o_alu_src;
    logic [1:0]      o_result_src;
    logic [2:0]      o_alu_control;
    logic [XLEN-1:0] o_rd1, o_rd2, o_pc, o_pc_plus4, o_imm_ext;
    logic [4:0]      o_rs1, o_rs2, o_rd;
    logic [CNTW-1:0] o_count;

    decode_execute_reg #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_StallE      (stall),
        .i_FlushE      (flush),
        .i_ValidD      (d.valid),
        .i_RegWriteD   (d.reg_write),
        .i_ResultSrcD  (d.result_src),
        .i_MemWriteD   (d.mem_write),
        .i_JumpD       (d.jump),
        .i_BranchD     (d.branch),
        .i_ALUControlD (d.alu_control),
        .i_ALUSrcD     (d.alu_src),
        .i_RD1D        (d.rd1),
        .i_RD2D        (d.rd2),
        .i_PCD         (d.pc),
        .i_PCPlus4D    (d.pc_plus4),
        .i_ImmExtD     (d.imm_ext),
        .i_Rs1D        (d.rs1),
        .i_Rs2D        (d.rs2),
        .i_RdD         (d.rd),
        .o_ValidE      (o_valid),
        .o_RegWriteE   (o_reg_write),
        .o_ResultSrcE  (o_result_src),
        .o_MemWriteE   (o_mem_write),
        .o_JumpE       (o_jump),
        .o_BranchE     (o_branch),
        .o_ALUControlE (o_alu_control),
        .o_ALUSrcE     (o_alu_src),
        .o_RD1E        (o_rd1),
        .o_RD2E        (o_rd2),
        .o_PCE         (o_pc),
        .o_PCPlus4E    (o_pc_plus4),
        .o_ImmExtE     (o_imm_ext),
        .o_Rs1E        (o_rs1),
        .o_Rs2E        (o_rs2),
        .o_RdE         (o_rd),
        .o_BubbleCount (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("valid",       32'(o_valid),       32'(exp_e.valid));
        checkOutput("reg_write",   32'(o_reg_write),   32'(exp_e.reg_write));
        checkOutput("result_src",  32'(o_result_src),  32'(exp_e.result_src));
        checkOutput("mem_write",   32'(o_mem_write),   32'(exp_e.mem_write));
        checkOutput("jump",        32'(o_jump),        32'(exp_e.jump));
        checkOutput("branch",      32'(o_branch),      32'(exp_e.branch));
        checkOutput("alu_control", 32'(o_alu_control), 32'(exp_e.alu_control));
        checkOutput("alu_src",     32'(o_alu_src),     32'(exp_e.alu_src));
        checkOutput("rd1",         o_rd1,              exp_e.rd1);
        checkOutput("rd2",         o_rd2,              exp_e.rd2);
        checkOutput("pc",          o_pc,               exp_e.pc);
        checkOutput("pc_plus4",    o_pc_plus4,         exp_e.pc_plus4);
        checkOutput("imm_ext",     o_imm_ext,          exp_e.imm_ext);
        checkOutput("rs1",         32'(o_rs1),         32'(exp_e.rs1));
        checkOutput("rs2",         32'(o_rs2),         32'(exp_e.rs2));
        checkOutput("rd",          32'(o_rd),          32'(exp_e.rd));
        checkOutput("bubbles",     32'(o_count),       32'(exp_count));
    endtask

    // One clock edge: the model decides what the stage should hold after the
    // edge from the controls and D values presented before it.
    task automatic applyStimulus(input logic r, input logic s, input logic f);
        stage_t nxt;
        int     nxt_count;
        reset = r;
        stall = s;
        flush = f;
        nxt       = exp_e;
        nxt_count = exp_count;
        if (r) begin
            nxt       = '0;
            nxt_count = 0;
        end else if (f) begin
            nxt       = '0;
            nxt_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
        end else if (!s) begin
            nxt = d;
        end
        @(posedge clk);
        #1;
        exp_e     = nxt;
        exp_count = nxt_count;
        checkAll();
    endtask

    task automatic randomD();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d = r[$bits(stage_t)-1:0];
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_e       = '0;
        exp_count   = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        d           = '1;
        d.rd1       = 32'hDEADBEEF;

        // Reset with busy D inputs, including a stall and flush that must lose.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_valid", 32'(o_valid), 32'h0);
        checkOutput("rst_rd1",   o_rd1,        32'h0);

        // Plain load of a known instruction.
        d             = '0;
        d.valid       = 1'b1;
        d.reg_write   = 1'b1;
        d.alu_control = 3'b010;
        d.rd          = 5'd7;
        d.pc          = 32'h100;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ld_regwrite", 32'(o_reg_write),   32'h1);
        checkOutput("ld_aluctl",   32'(o_alu_control), 32'h2);
        checkOutput("ld_rd",       32'(o_rd),          32'h7);
        checkOutput("ld_pc",       o_pc,               32'h100);
        checkOutput("ld_valid",    32'(o_valid),       32'h1);

        // Stall holds the old PC while D moves on.
        d.pc = 32'h104;
        applyStimulus(1'b0, 1'b0, 1'b0);
        d.pc = 32'h108;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("stall_pc", o_pc, 32'h104);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("unstall_pc", o_pc, 32'h108);

        // Flush a valid store into a bubble.
        d.mem_write = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pre_flush_memwrite", 32'(o_mem_write), 32'h1);
        checkOutput("pre_flush_count",    32'(o_count),     32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("flush_memwrite", 32'(o_mem_write), 32'h0);
        checkOutput("flush_regwrite", 32'(o_reg_write), 32'h0);
        checkOutput("flush_valid",    32'(o_valid),     32'h0);
        checkOutput("flush_count",    32'(o_count),     32'h1);

        // Flush beats stall.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("flush_stall_valid", 32'(o_valid), 32'h0);
        checkOutput("flush_stall_count", 32'(o_count), 32'h2);

        // Counter saturation from a fresh reset.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("sat_count", 32'(o_count), (i < 3) ? 32'(i) : 32'd3);
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomD();
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
